pc_call_stack: RTL and testbench

//  Parametrised program-counter slice with a subroutine return-address LIFO for the MC14500B-based controller.

---
 rtl/pc_stack_pkg.sv | 17 +
 rtl/lifo_mem.sv | 50 +++++
 rtl/pc_call_stack.sv | 97 +++++++++
 tb/tb_pc_call_stack.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_stack_pkg.sv
// Opcode definitions for the PC slice with return-address stack.
// Shared by the PC slice top and its testbench.
package pc_stack_pkg;

   typedef enum logic [1:0] {
      OP_INC  = 2'b00,
      OP_JMP  = 2'b01,
      OP_CALL = 2'b10,
      OP_RET  = 2'b11
   } op_e;

   localparam logic [1:0] OPC_INC  = 2'b00;
   localparam logic [1:0] OPC_JMP  = 2'b01;
   localparam logic [1:0] OPC_CALL = 2'b10;
   localparam logic [1:0] OPC_RET  = 2'b11;

endpackage

// File: rtl/lifo_mem.sv
// Return-address LIFO: storage array plus occupancy count.
// Only count is reset; stale entries are hidden by count.
module lifo_mem
   import pc_stack_pkg::*;
#(
   parameter int WORD      = 4,
   parameter int DEPTH_LOG = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic            pop,
   input  logic [WORD-1:0] wdata,
   output logic [WORD-1:0] top,
   output logic            full,
   output logic            empty
);

   localparam int DEPTH = 2 ** DEPTH_LOG;

   logic [WORD-1:0]      mem [DEPTH];
   logic [DEPTH_LOG:0]   count;
   logic [DEPTH_LOG-1:0] wr_idx;
   logic [DEPTH_LOG-1:0] top_idx;

   assign wr_idx  = count[DEPTH_LOG-1:0];
   assign top_idx = wr_idx - 1'b1;
   assign top     = mem[top_idx];
   assign full    = (count == (DEPTH_LOG+1)'(DEPTH));
   assign empty   = (count == '0);

   // Storage write on push; contents are never cleared.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_idx] <= wdata;
      end
   end

   // Occupancy count; caller guarantees no push when full / pop when empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (push) begin
         count <= count + 1'b1;
      end else if (pop) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/pc_call_stack.sv
// Cascadable PC slice with CALL/RET return-address stack.
// Define PC_STACK_ERR_EN to enable the sticky stack_err flag.
module pc_call_stack
   import pc_stack_pkg::*;
#(
   parameter int WORD      = 4,
   parameter int DEPTH_LOG = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            execute,
   input  logic [1:0]      instruction,
   input  logic            carry_in,
   input  logic [WORD-1:0] data_in,
   input  logic            output_enable,
   output logic [WORD-1:0] address_out,
   output logic [WORD-1:0] data_out,
   output logic            carry_out,
   output logic            stack_full,
   output logic            stack_empty,
   output logic            stack_err
);

   op_e             op;
   logic [WORD-1:0] pc;
   logic [WORD-1:0] pc_inc;
   logic [WORD-1:0] pc_nxt;
   logic [WORD-1:0] top;
   logic            push;
   logic            pop;
   logic            is_call;
   logic            is_ret;

   assign op      = op_e'(instruction);
   assign pc_inc  = pc + WORD'(carry_in);
   assign is_call = execute && (op == OP_CALL);
   assign is_ret  = execute && (op == OP_RET);
   assign push    = is_call && !stack_full;
   assign pop     = is_ret && !stack_empty;

   lifo_mem #(
      .WORD      (WORD),
      .DEPTH_LOG (DEPTH_LOG)
   ) u_lifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (pc_inc),
      .top   (top),
      .full  (stack_full),
      .empty (stack_empty)
   );

   // Next-PC selection; RET on an empty stack leaves the PC alone.
   always_comb begin
      pc_nxt = pc;
      unique case (op)
         OP_INC:  pc_nxt = pc_inc;
         OP_JMP:  pc_nxt = data_in;
         OP_CALL: pc_nxt = data_in;
         OP_RET:  pc_nxt = stack_empty ? pc : top;
         default: pc_nxt = pc;
      endcase
   end

   // PC register, updated only on an execute strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= '0;
      end else if (execute) begin
         pc <= pc_nxt;
      end
   end

   assign address_out = pc;
   assign carry_out   = carry_in && (pc == '1);
   assign data_out    = (output_enable && !stack_empty) ? top : '0;

`ifdef PC_STACK_ERR_EN
   logic err_q;

   // Sticky flag for overflowing CALL or underflowing RET.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if ((is_call && stack_full) || (is_ret && stack_empty)) begin
         err_q <= 1'b1;
      end
   end

   assign stack_err = err_q;
`else
   assign stack_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_call_stack.sv
// Directed testbench for pc_call_stack.
// Expected stack_err follows PC_STACK_ERR_EN.
module tb_pc_call_stack;
   import pc_stack_pkg::*;

`ifdef PC_STACK_ERR_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       execute = 1'b0;
   logic [1:0] instruction = OPC_INC;
   logic       carry_in = 1'b0;
   logic [3:0] data_in = 4'h0;
   logic       output_enable = 1'b1;
   logic [3:0] address_out;
   logic [3:0] data_out;
   logic       carry_out;
   logic       stack_full;
   logic       stack_empty;
   logic       stack_err;

   int vecs = 0;
   int bad = 0;

   always #5 clk = ~clk;

   pc_call_stack #(.WORD(4), .DEPTH_LOG(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .execute       (execute),
      .instruction   (instruction),
      .carry_in      (carry_in),
      .data_in       (data_in),
      .output_enable (output_enable),
      .address_out   (address_out),
      .data_out      (data_out),
      .carry_out     (carry_out),
      .stack_full    (stack_full),
      .stack_empty   (stack_empty),
      .stack_err     (stack_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic [1:0] o, input logic ci, input logic [3:0] d);
      execute     = 1'b1;
      instruction = o;
      carry_in    = ci;
      data_in     = d;
      tick();
      execute     = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vecs++;
      if (address_out !== 4'h0) begin
         bad++;
         $display("FAIL reset_pc got %h want 0", address_out);
      end
      vecs++;
      if (data_out !== 4'h0 || stack_empty !== 1'b1 || stack_full !== 1'b0 || stack_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_flags got do=%h e=%b f=%b err=%b want 0 1 0 0",
                  data_out, stack_empty, stack_full, stack_err);
      end
   endtask

   task automatic test_inc();
      for (int i = 1; i <= 5; i++) begin
         op(OPC_INC, 1'b1, 4'h0);
         vecs++;
         if (address_out !== 4'(i)) begin
            bad++;
            $display("FAIL inc_%0d got %h want %h", i, address_out, 4'(i));
         end
      end
      op(OPC_INC, 1'b0, 4'h0);
      vecs++;
      if (address_out !== 4'h5) begin
         bad++;
         $display("FAIL inc_hold got %h want 5", address_out);
      end
   endtask

   task automatic test_wrap();
      op(OPC_JMP, 1'b0, 4'hE);
      op(OPC_INC, 1'b1, 4'h0);
      carry_in = 1'b1;
      #1;
      vecs++;
      if (address_out !== 4'hF || carry_out !== 1'b1) begin
         bad++;
         $display("FAIL wrap_f got pc=%h co=%b want F 1", address_out, carry_out);
      end
      carry_in = 1'b0;
      #1;
      vecs++;
      if (carry_out !== 1'b0) begin
         bad++;
         $display("FAIL carry_gate got %b want 0", carry_out);
      end
      op(OPC_INC, 1'b1, 4'h0);
      carry_in = 1'b0;
      #1;
      vecs++;
      if (address_out !== 4'h0 || carry_out !== 1'b0) begin
         bad++;
         $display("FAIL wrap_0 got pc=%h co=%b want 0 0", address_out, carry_out);
      end
   endtask

   task automatic test_call_ret();
      op(OPC_JMP, 1'b0, 4'h3);
      op(OPC_CALL, 1'b1, 4'hA);
      output_enable = 1'b1;
      #1;
      vecs++;
      if (address_out !== 4'hA || data_out !== 4'h4 || stack_empty !== 1'b0) begin
         bad++;
         $display("FAIL call got pc=%h do=%h e=%b want A 4 0",
                  address_out, data_out, stack_empty);
      end
      output_enable = 1'b0;
      #1;
      vecs++;
      if (data_out !== 4'h0) begin
         bad++;
         $display("FAIL oe_gate got %h want 0", data_out);
      end
      output_enable = 1'b1;
      op(OPC_RET, 1'b0, 4'h0);
      vecs++;
      if (address_out !== 4'h4 || stack_empty !== 1'b1 || data_out !== 4'h0) begin
         bad++;
         $display("FAIL ret got pc=%h e=%b do=%h want 4 1 0",
                  address_out, stack_empty, data_out);
      end
   endtask

   task automatic test_full();
      logic [3:0] exp_stk [16];
      logic [3:0] mpc;
      mpc = address_out;
      for (int i = 1; i <= 16; i++) begin
         exp_stk[i-1] = mpc + 4'h1;
         op(OPC_CALL, 1'b1, 4'(i));
         mpc = 4'(i);
      end
      vecs++;
      if (stack_full !== 1'b1 || address_out !== 4'h0 || data_out !== exp_stk[15]) begin
         bad++;
         $display("FAIL full got f=%b pc=%h do=%h want 1 0 %h",
                  stack_full, address_out, data_out, exp_stk[15]);
      end
      op(OPC_CALL, 1'b1, 4'h7);
      vecs++;
      if (address_out !== 4'h7 || stack_full !== 1'b1 || stack_err !== ERR_ON
          || data_out !== exp_stk[15]) begin
         bad++;
         $display("FAIL overflow got pc=%h f=%b err=%b do=%h want 7 1 %b %h",
                  address_out, stack_full, stack_err, data_out, ERR_ON, exp_stk[15]);
      end
      for (int j = 15; j >= 0; j--) begin
         op(OPC_RET, 1'b0, 4'h0);
         vecs++;
         if (address_out !== exp_stk[j]) begin
            bad++;
            $display("FAIL unwind_%0d got %h want %h", j, address_out, exp_stk[j]);
         end
      end
      vecs++;
      if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin
         bad++;
         $display("FAIL unwound got e=%b f=%b want 1 0", stack_empty, stack_full);
      end
   endtask

   task automatic test_ret_empty();
      do_reset();
      op(OPC_JMP, 1'b0, 4'h9);
      op(OPC_RET, 1'b0, 4'h0);
      vecs++;
      if (address_out !== 4'h9 || stack_empty !== 1'b1 || stack_err !== ERR_ON) begin
         bad++;
         $display("FAIL ret_empty got pc=%h e=%b err=%b want 9 1 %b",
                  address_out, stack_empty, stack_err, ERR_ON);
      end
      execute     = 1'b0;
      instruction = OPC_CALL;
      data_in     = 4'h3;
      carry_in    = 1'b1;
      tick();
      instruction = OPC_INC;
      tick();
      instruction = OPC_JMP;
      tick();
      vecs++;
      if (address_out !== 4'h9 || stack_empty !== 1'b1) begin
         bad++;
         $display("FAIL no_exec got pc=%h e=%b want 9 1", address_out, stack_empty);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      op(OPC_JMP, 1'b0, 4'h6);
      op(OPC_CALL, 1'b0, 4'hC);
      op(OPC_RET, 1'b0, 4'h0);
      vecs++;
      if (address_out !== 4'h6 || stack_empty !== 1'b1) begin
         bad++;
         $display("FAIL b2b got pc=%h e=%b want 6 1", address_out, stack_empty);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      op(OPC_RET, 1'b0, 4'h0);
      op(OPC_CALL, 1'b1, 4'h2);
      op(OPC_CALL, 1'b1, 4'h5);
      op(OPC_CALL, 1'b1, 4'hB);
      vecs++;
      if (address_out !== 4'hB || data_out !== 4'h6 || stack_err !== ERR_ON) begin
         bad++;
         $display("FAIL pre_reset got pc=%h do=%h err=%b want B 6 %b",
                  address_out, data_out, stack_err, ERR_ON);
      end
      execute     = 1'b1;
      instruction = OPC_CALL;
      data_in     = 4'hD;
      do_reset();
      execute = 1'b0;
      vecs++;
      if (address_out !== 4'h0 || stack_empty !== 1'b1 || stack_err !== 1'b0
          || data_out !== 4'h0) begin
         bad++;
         $display("FAIL mid_reset got pc=%h e=%b err=%b do=%h want 0 1 0 0",
                  address_out, stack_empty, stack_err, data_out);
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_inc();
      test_wrap();
      test_call_ret();
      test_full();
      test_ret_empty();
      test_back_to_back();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
      $finish;
   end

endmodule
